// File: rtl/ddr3_ram_arb.sv
// ddr3_ram_arb: round-robin arbiter merging NUM_PORTS RAM request ports onto one DDR3 core channel.
// Optional per-port outstanding-request limit enabled by defining DDR3_ARB_OUTSTANDING_LIMIT_EN.
module ddr3_ram_arb #(
   parameter int NUM_PORTS       = 2,
   parameter int PORT_W          = 1,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [NUM_PORTS*16-1:0]  inport_wr_i,
   input  logic [NUM_PORTS-1:0]     inport_rd_i,
   input  logic [NUM_PORTS*32-1:0]  inport_addr_i,
   input  logic [NUM_PORTS*128-1:0] inport_write_data_i,
   input  logic [NUM_PORTS*16-1:0]  inport_req_id_i,
   output logic [NUM_PORTS-1:0]     inport_accept_o,
   output logic [NUM_PORTS-1:0]     inport_ack_o,
   output logic [NUM_PORTS-1:0]     inport_error_o,
   output logic [127:0]             inport_read_data_o,
   output logic [15:0]              inport_resp_id_o,
   output logic [15:0]              outport_wr_o,
   output logic                     outport_rd_o,
   output logic [31:0]              outport_addr_o,
   output logic [127:0]             outport_write_data_o,
   output logic [15:0]              outport_req_id_o,
   input  logic                     outport_accept_i,
   input  logic                     outport_ack_i,
   input  logic                     outport_error_i,
   input  logic [127:0]             outport_read_data_i,
   input  logic [15:0]              outport_resp_id_i
);
   localparam int ID_LO_W = 16 - PORT_W;

   logic [NUM_PORTS-1:0] req_s;
   logic [NUM_PORTS-1:0] mask_s;
   logic [NUM_PORTS-1:0] cand_s;
   logic [NUM_PORTS-1:0] grant_s;
   logic [PORT_W-1:0]    grant_idx_s;
   logic                 grant_any_s;
   logic                 free_s;
   logic [NUM_PORTS-1:0] ack_route_s;
   logic [PORT_W-1:0]    resp_idx_s;

   logic [15:0]          sel_wr_s;
   logic                 sel_rd_s;
   logic [31:0]          sel_addr_s;
   logic [127:0]         sel_data_s;
   logic [ID_LO_W-1:0]   sel_id_lo_s;

   logic                 valid_q, valid_d;
   logic [15:0]          wr_q, wr_d;
   logic                 rd_q, rd_d;
   logic [31:0]          addr_q, addr_d;
   logic [127:0]         data_q, data_d;
   logic [15:0]          id_q, id_d;
   logic [PORT_W-1:0]    last_q, last_d;
   logic [NUM_PORTS-1:0] ack_q, ack_d;
   logic [NUM_PORTS-1:0] err_q, err_d;
   logic [127:0]         rdata_q, rdata_d;
   logic [15:0]          rid_q, rid_d;

   // Per-port request detection: any write strobe or the read bit.
   always_comb begin
      req_s = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         req_s[p] = (|inport_wr_i[16*p +: 16]) | inport_rd_i[p];
      end
   end

   // Round-robin pick: first scan ports above last_q, then wrap to ports at or below it.
   always_comb begin
      free_s      = ~valid_q | outport_accept_i;
      cand_s      = req_s & ~mask_s & {NUM_PORTS{free_s}};
      grant_s     = '0;
      grant_idx_s = '0;
      grant_any_s = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (!grant_any_s && cand_s[p] && (PORT_W'(p) > last_q)) begin
            grant_any_s = 1'b1;
            grant_s[p]  = 1'b1;
            grant_idx_s = PORT_W'(p);
         end else begin
            grant_any_s = grant_any_s;
         end
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (!grant_any_s && cand_s[p] && (PORT_W'(p) <= last_q)) begin
            grant_any_s = 1'b1;
            grant_s[p]  = 1'b1;
            grant_idx_s = PORT_W'(p);
         end else begin
            grant_any_s = grant_any_s;
         end
      end
   end

   // Reset gates the combinational accept so outputs read zero while rst_n_i is low.
   assign inport_accept_o = grant_s & {NUM_PORTS{rst_n_i}};

   // One-hot AND-OR mux of the granted port's request fields.
   always_comb begin
      sel_wr_s    = '0;
      sel_rd_s    = 1'b0;
      sel_addr_s  = '0;
      sel_data_s  = '0;
      sel_id_lo_s = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         sel_wr_s    = sel_wr_s    | (inport_wr_i[16*p +: 16]          & {16{grant_s[p]}});
         sel_rd_s    = sel_rd_s    | (inport_rd_i[p]                   & grant_s[p]);
         sel_addr_s  = sel_addr_s  | (inport_addr_i[32*p +: 32]        & {32{grant_s[p]}});
         sel_data_s  = sel_data_s  | (inport_write_data_i[128*p +: 128] & {128{grant_s[p]}});
         sel_id_lo_s = sel_id_lo_s | (inport_req_id_i[16*p +: ID_LO_W] & {ID_LO_W{grant_s[p]}});
      end
   end

   // Output request register: load on grant, drain on core accept, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      data_d  = data_q;
      id_d    = id_q;
      last_d  = last_q;
      if (grant_any_s) begin
         valid_d = 1'b1;
         wr_d    = sel_wr_s;
         rd_d    = sel_rd_s;
         addr_d  = sel_addr_s;
         data_d  = sel_data_s;
         id_d    = {grant_idx_s, sel_id_lo_s};
         last_d  = grant_idx_s;
      end else if (valid_q && outport_accept_i) begin
         valid_d = 1'b0;
         wr_d    = 16'h0000;
         rd_d    = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Response routing; indices at or beyond NUM_PORTS match no port and are dropped.
   assign resp_idx_s = outport_resp_id_i[15 -: PORT_W];

   // Decode the response port index into a one-hot routed ack.
   always_comb begin
      ack_route_s = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         ack_route_s[p] = outport_ack_i & (resp_idx_s == PORT_W'(p));
      end
   end

   // Response register next state: single-cycle ack, data/ID captured on a routed ack.
   always_comb begin
      ack_d   = ack_route_s;
      err_d   = ack_route_s & {NUM_PORTS{outport_error_i}};
      rdata_d = rdata_q;
      rid_d   = rid_q;
      if (|ack_route_s) begin
         rdata_d = outport_read_data_i;
         rid_d   = {{PORT_W{1'b0}}, outport_resp_id_i[ID_LO_W-1:0]};
      end else begin
         rdata_d = rdata_q;
      end
   end

`ifdef DDR3_ARB_OUTSTANDING_LIMIT_EN
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [CNT_W-1:0] cnt_q [NUM_PORTS];
   logic [CNT_W-1:0] cnt_d [NUM_PORTS];

   // A port at its outstanding limit is removed from arbitration.
   always_comb begin
      mask_s = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         mask_s[p] = (cnt_q[p] == CNT_W'(MAX_OUTSTANDING));
      end
   end

   // Outstanding counters: grant and routed ack in the same cycle cancel out.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         cnt_d[p] = cnt_q[p];
         if (grant_s[p] && !ack_route_s[p]) begin
            cnt_d[p] = cnt_q[p] + CNT_W'(1);
         end else if (!grant_s[p] && ack_route_s[p] && (cnt_q[p] != CNT_W'(0))) begin
            cnt_d[p] = cnt_q[p] - CNT_W'(1);
         end else begin
            cnt_d[p] = cnt_q[p];
         end
      end
   end

   // Counter state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_q[p] <= cnt_d[p];
         end
      end
   end
`else
   assign mask_s = '0;
`endif

   // Request and response state registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= 1'b0;
         wr_q    <= 16'h0000;
         rd_q    <= 1'b0;
         addr_q  <= 32'h0000_0000;
         data_q  <= '0;
         id_q    <= 16'h0000;
         last_q  <= PORT_W'(NUM_PORTS - 1);
         ack_q   <= '0;
         err_q   <= '0;
         rdata_q <= '0;
         rid_q   <= 16'h0000;
      end else begin
         valid_q <= valid_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         id_q    <= id_d;
         last_q  <= last_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         rid_q   <= rid_d;
      end
   end

   assign outport_wr_o         = wr_q;
   assign outport_rd_o         = rd_q;
   assign outport_addr_o       = addr_q;
   assign outport_write_data_o = data_q;
   assign outport_req_id_o     = id_q;
   assign inport_ack_o         = ack_q;
   assign inport_error_o       = err_q;
   assign inport_read_data_o   = rdata_q;
   assign inport_resp_id_o     = rid_q;

endmodule

// File: tb/tb_ddr3_ram_arb.sv
// Directed table-driven bench for ddr3_ram_arb: a 2-port instance and a 4-port instance with 3-bit port index.
module tb_ddr3_ram_arb;

`ifdef DDR3_ARB_OUTSTANDING_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   localparam logic [127:0] RDATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
   localparam logic [127:0] WD0   = {4{32'hAAAA_0000}};
   localparam logic [127:0] WD1   = {4{32'hBBBB_1111}};

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // DUT A: 2 ports
   logic [31:0]  a_wr;
   logic [1:0]   a_rd;
   logic [63:0]  a_addr;
   logic [255:0] a_wdata;
   logic [31:0]  a_reqid;
   logic [1:0]   a_acc, a_iack, a_ierr;
   logic [127:0] a_irdata;
   logic [15:0]  a_irid;
   logic [15:0]  a_owr;
   logic         a_ord;
   logic [31:0]  a_oaddr;
   logic [127:0] a_owdata;
   logic [15:0]  a_oid;
   logic         a_oacc, a_oack, a_oerr;
   logic [15:0]  a_orid;

   // DUT B: 4 ports, 3-bit port index field
   logic [63:0]  b_wr;
   logic [3:0]   b_rd;
   logic [127:0] b_addr;
   logic [511:0] b_wdata;
   logic [63:0]  b_reqid;
   logic [3:0]   b_acc, b_iack, b_ierr;
   logic [127:0] b_irdata;
   logic [15:0]  b_irid;
   logic [15:0]  b_owr;
   logic         b_ord;
   logic [31:0]  b_oaddr;
   logic [127:0] b_owdata;
   logic [15:0]  b_oid;
   logic         b_oacc, b_oack, b_oerr;
   logic [15:0]  b_orid;

   ddr3_ram_arb #(.NUM_PORTS(2), .PORT_W(1), .MAX_OUTSTANDING(4)) u_a (
      .clk_i(clk), .rst_n_i(rst_a),
      .inport_wr_i(a_wr), .inport_rd_i(a_rd), .inport_addr_i(a_addr),
      .inport_write_data_i(a_wdata), .inport_req_id_i(a_reqid),
      .inport_accept_o(a_acc), .inport_ack_o(a_iack), .inport_error_o(a_ierr),
      .inport_read_data_o(a_irdata), .inport_resp_id_o(a_irid),
      .outport_wr_o(a_owr), .outport_rd_o(a_ord), .outport_addr_o(a_oaddr),
      .outport_write_data_o(a_owdata), .outport_req_id_o(a_oid),
      .outport_accept_i(a_oacc), .outport_ack_i(a_oack), .outport_error_i(a_oerr),
      .outport_read_data_i(RDATA), .outport_resp_id_i(a_orid)
   );

   ddr3_ram_arb #(.NUM_PORTS(4), .PORT_W(3), .MAX_OUTSTANDING(2)) u_b (
      .clk_i(clk), .rst_n_i(rst_b),
      .inport_wr_i(b_wr), .inport_rd_i(b_rd), .inport_addr_i(b_addr),
      .inport_write_data_i(b_wdata), .inport_req_id_i(b_reqid),
      .inport_accept_o(b_acc), .inport_ack_o(b_iack), .inport_error_o(b_ierr),
      .inport_read_data_o(b_irdata), .inport_resp_id_o(b_irid),
      .outport_wr_o(b_owr), .outport_rd_o(b_ord), .outport_addr_o(b_oaddr),
      .outport_write_data_o(b_owdata), .outport_req_id_o(b_oid),
      .outport_accept_i(b_oacc), .outport_ack_i(b_oack), .outport_error_i(b_oerr),
      .outport_read_data_i(RDATA), .outport_resp_id_i(b_orid)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [1:0]  rd;
      logic        oacc;
      logic        oack;
      logic        oerr;
      logic [15:0] rid_in;
      logic [1:0]  e_acc;
      logic        e_ord;
      logic [15:0] e_oid;
      logic [1:0]  e_iack;
      logic [1:0]  e_ierr;
      logic [15:0] e_rid;
   } vec_t;

   vec_t tbl [15];

   initial begin
      // rows: inputs applied this cycle | accept now, registered outputs from the previous edge
      tbl[0]  = '{2'b11, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b0, 16'h0000, 2'b00, 2'b00, 16'h0000};
      tbl[1]  = '{2'b11, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b10, 1'b1, 16'h0011, 2'b00, 2'b00, 16'h0000};
      tbl[2]  = '{2'b11, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b1, 16'h8022, 2'b00, 2'b00, 16'h0000};
      tbl[3]  = '{2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 16'h0011, 2'b00, 2'b00, 16'h0000};
      tbl[4]  = '{2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 16'h0011, 2'b00, 2'b00, 16'h0000};
      tbl[5]  = '{2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 16'h0011, 2'b00, 2'b00, 16'h0000};
      tbl[6]  = '{2'b00, 1'b0, 1'b1, 1'b0, 16'h8005, 2'b00, 1'b0, 16'h0000, 2'b00, 2'b00, 16'h0000};
      tbl[7]  = '{2'b10, 1'b1, 1'b1, 1'b1, 16'h0007, 2'b10, 1'b0, 16'h0000, 2'b10, 2'b00, 16'h0005};
      tbl[8]  = '{2'b01, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b1, 16'h8022, 2'b01, 2'b01, 16'h0007};
      tbl[9]  = '{2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 16'h0011, 2'b00, 2'b00, 16'h0000};
      tbl[10] = '{2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b0, 16'h0000, 2'b00, 2'b00, 16'h0000};
      tbl[11] = '{2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 16'h0011, 2'b00, 2'b00, 16'h0000};
      tbl[12] = '{2'b11, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b10, 1'b1, 16'h0011, 2'b00, 2'b00, 16'h0000};
      tbl[13] = '{2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 16'h8022, 2'b00, 2'b00, 16'h0000};
      tbl[14] = '{2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b00, 2'b00, 16'h0000};

      rst_a = 1'b0; rst_b = 1'b0;
      a_wr = '0; a_rd = 2'b11; a_oacc = 1'b0; a_oack = 1'b0; a_oerr = 1'b0; a_orid = '0;
      a_addr  = {32'h0000_0100, 32'h0000_1000};
      a_wdata = {WD1, WD0};
      a_reqid = {16'h0022, 16'h0011};
      b_wr = '0; b_rd = '0; b_oacc = 1'b0; b_oack = 1'b0; b_oerr = 1'b0; b_orid = '0;
      b_addr  = {32'h0000_2030, 32'h0000_2020, 32'h0000_2010, 32'h0000_2000};
      b_wdata = {4{WD0}};
      b_reqid = {16'h0043, 16'h0032, 16'h0021, 16'h0010};

      #13;
      chk("reset accept", a_acc, 2'b00);
      chk("reset out rd", a_ord, 1'b0);
      chk("reset out wr", a_owr, 16'h0000);
      chk("reset out id", a_oid, 16'h0000);
      chk("reset in ack", a_iack, 2'b00);
      chk("reset rdata", a_irdata, 128'h0);

      @(posedge clk);
      #1;
      rst_a = 1'b1; rst_b = 1'b1;

      for (int i = 0; i < 15; i++) begin
         a_rd = tbl[i].rd; a_oacc = tbl[i].oacc; a_oack = tbl[i].oack;
         a_oerr = tbl[i].oerr; a_orid = tbl[i].rid_in;
         #1;
         chk($sformatf("row%0d accept", i), a_acc, tbl[i].e_acc);
         chk($sformatf("row%0d out rd", i), a_ord, tbl[i].e_ord);
         chk($sformatf("row%0d out wr", i), a_owr, 16'h0000);
         if (tbl[i].e_ord) begin
            chk($sformatf("row%0d out id", i), a_oid, tbl[i].e_oid);
            chk($sformatf("row%0d out addr", i), a_oaddr,
                tbl[i].e_oid[15] ? 32'h0000_0100 : 32'h0000_1000);
         end
         chk($sformatf("row%0d in ack", i), a_iack, tbl[i].e_iack);
         chk($sformatf("row%0d in err", i), a_ierr, tbl[i].e_ierr);
         if (tbl[i].e_iack != 2'b00) begin
            chk($sformatf("row%0d resp id", i), a_irid, tbl[i].e_rid);
            chk($sformatf("row%0d rdata", i), a_irdata, RDATA);
         end
         tick();
      end

      // Port 1 write held by core backpressure for three cycles
      a_rd = 2'b00; a_wr = {16'hFFFF, 16'h0000}; a_oacc = 1'b0; a_oack = 1'b0;
      #1;
      chk("wr grant", a_acc, 2'b10);
      tick();
      for (int k = 0; k < 4; k++) begin
         a_oacc = (k == 3);
         if (k == 3) a_wr = '0;
         #1;
         chk($sformatf("hold%0d accept", k), a_acc, 2'b00);
         chk($sformatf("hold%0d out wr", k), a_owr, 16'hFFFF);
         chk($sformatf("hold%0d out rd", k), a_ord, 1'b0);
         chk($sformatf("hold%0d out addr", k), a_oaddr, 32'h0000_0100);
         chk($sformatf("hold%0d out data", k), a_owdata, WD1);
         chk($sformatf("hold%0d out id", k), a_oid, 16'h8022);
         tick();
      end
      a_oacc = 1'b0;
      #1;
      chk("drained wr", a_owr, 16'h0000);
      chk("drained rd", a_ord, 1'b0);

      // DUT B: mid-operation reset
      tick();
      b_rd = 4'b0010;
      #1;
      chk("b first grant", b_acc, 4'b0010);
      tick();
      b_rd = 4'b1101; b_oack = 1'b1; b_orid = 16'h2005;
      #1;
      chk("b busy accept", b_acc, 4'b0000);
      chk("b out rd", b_ord, 1'b1);
      chk("b out id", b_oid, 16'h2021);
      tick();
      b_oack = 1'b0;
      #1;
      chk("b ack p1", b_iack, 4'b0010);
      chk("b resp id", b_irid, 16'h0005);
      rst_b = 1'b0;
      #1;
      chk("b rst out rd", b_ord, 1'b0);
      chk("b rst out id", b_oid, 16'h0000);
      chk("b rst ack", b_iack, 4'b0000);
      chk("b rst accept", b_acc, 4'b0000);
      chk("b rst resp id", b_irid, 16'h0000);
      tick();
      chk("b rst held", b_ord, 1'b0);
      rst_b = 1'b1;
      #1;
      chk("b post-rst grant", b_acc, 4'b0001);
      tick();

      // DUT B: outstanding limit on port 0
      b_rd = 4'b0001; b_oacc = 1'b1;
      #1;
      chk("b 2nd read", b_acc, 4'b0001);
      chk("b out id p0", b_oid, 16'h0010);
      tick();
      #1;
      chk("b 3rd read blocked", b_acc, LIMIT ? 4'b0000 : 4'b0001);
      tick();
      b_oack = 1'b1; b_orid = 16'h0003;
      #1;
      chk("b blocked on ack", b_acc, LIMIT ? 4'b0000 : 4'b0001);
      tick();
      b_oack = 1'b0;
      #1;
      chk("b 3rd read granted", b_acc, 4'b0001);
      chk("b ack p0", b_iack, 4'b0001);
      chk("b resp id p0", b_irid, 16'h0003);
      tick();

      // DUT B: out-of-range response indices
      b_rd = 4'b0000; b_oack = 1'b1; b_orid = 16'hA001;
      tick();
      b_orid = 16'h8001;
      #1;
      chk("b idx5 ignored", b_iack, 4'b0000);
      tick();
      b_orid = 16'h6001; b_oerr = 1'b1;
      #1;
      chk("b idx4 ignored", b_iack, 4'b0000);
      tick();
      b_oack = 1'b0; b_oerr = 1'b0;
      #1;
      chk("b ack p3", b_iack, 4'b1000);
      chk("b err p3", b_ierr, 4'b1000);
      chk("b resp id p3", b_irid, 16'h0001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
